mips_uart_tx_port: RTL and testbench
====================================

# mips_uart_tx_port

Memory-mapped UART transmitter on the processor's MEM-stage data bus, in parallel with the data memory and decoded by address. Store-word writes to its data address push a byte into a small FIFO. A serialiser state machine drains the FIFO onto a single TX line as 8N1 frames. Software polls a status word through a load to the status address.

## Interface
- `BASE_ADDR`, default 32'h1001_0040: byte address of the TXDATA register; STATUS is at `BASE_ADDR+4`.
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit, must be ≥2. 434 gives 115200 baud at 50 MHz.
- `FIFO_DEPTH`, default 8: number of byte entries, must be a power of 2 and ≥2.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `MemWrite`  in  1  store strobe from the EX/MEM register.
- `MemRead`  in  1  load strobe from the EX/MEM register.
- `Address`  in  32  byte address from the EX/MEM ALU result.
- `WriteData`  in  32  store data; only bits [7:0] are used.
- `ReadData`  out  32  load data; combinational.
- `Tx`  out  1  serial output, registered, idle high.
- `Irq`  out  1  level output, high while the FIFO is empty and the serialiser is idle.

## Operation
**Address decode**
- The block is selected when `Address[31:2]` equals `BASE_ADDR[31:2]` (TXDATA) or `(BASE_ADDR+4)[31:2]` (STATUS).
- `Address[1:0]` is ignored.

**TXDATA write**
- `MemWrite` with TXDATA selected pushes `WriteData[7:0]` into the FIFO at the clock edge.
- Reading TXDATA returns 0.

**STATUS read**
- `ReadData = {27'b0, overflow, fifo_empty, fifo_full, busy, Irq}`.
  - `busy` is high when the state is not IDLE.
  - `overflow` is a sticky bit.
- Any `MemWrite` to STATUS clears `overflow`. Write data is ignored.

**Unselected**
- `ReadData = 0` whenever the block is not selected or `MemRead` is low.

**FIFO**
- Circular buffer with read and write pointers of `log2(FIFO_DEPTH)+1` bits. The extra MSB distinguishes full from empty.
- Pointers wrap modulo `2*FIFO_DEPTH`.
- A push while full is dropped and sets `overflow`. Exception: if a pop occurs on the same edge, the push is accepted.
- A push and pop on the same edge when neither full nor empty leave the occupancy unchanged.

**Serialiser FSM (IDLE, START, DATA, STOP)**
- **IDLE:** `Tx=1`. If the FIFO is non-empty: pop the head into the shift register, clear the bit counter, go to START.
- **START:** `Tx=0` for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA:** `Tx=shift[0]` for `CLKS_PER_BIT` cycles per bit, shift right, 8 bits LSB-first; after bit 7, go to STOP.
- **STOP:** `Tx=1` for `CLKS_PER_BIT` cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle cycle between frames); otherwise go to IDLE.
- A baud counter counts 0..`CLKS_PER_BIT-1` and reloads to 0 on every state change.

## Timing
- **Reset values** (asynchronous, immediate): `Tx=1`, state IDLE, FIFO empty, pointers 0, counters 0, `overflow=0`, `Irq=1`.
  - `ReadData` follows its combinational rule; with reset asserted it reads 0 except STATUS, which reads 32'h0000_0009 (`Irq`=1, `fifo_empty`=1).
- **Reset mid-frame:** the frame is aborted, `Tx` returns high immediately, and queued bytes are discarded.
- **Push to start bit:** a push at edge N is popped at edge N+1 if IDLE; `Tx` falls after edge N+1.
- **Frame length:** exactly `10*CLKS_PER_BIT` cycles from the `Tx` falling edge to the end of the stop bit.
- **Back-to-back frames:** the next start bit begins on the cycle after the last stop-bit cycle.
- **Status reads** reflect register state before the current edge. A push in the same cycle is not yet visible.
- **Irq** is registered-state derived. It falls the cycle after a push while idle, and rises the cycle after the final STOP completes with the FIFO empty.

## Configuration
- **`UART_TX_PARITY_EN` defined:**
  - A PARITY state is inserted between DATA and STOP.
  - PARITY drives even parity (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles.
  - Frame length becomes `11*CLKS_PER_BIT`.
- **Undefined:** no PARITY state; 8N1 frames, 10 bit-times each.
- The STATUS layout is identical in both builds.

## Test plan
- **Reset:** assert `reset` mid-STOP with `CLKS_PER_BIT=4` -> `Tx=1` immediately; STATUS reads 32'h9; no further frame after release.
- **Single byte:** write 32'h0000_0155 to TXDATA -> `Tx` low 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles; 40 cycles total; `Irq` returns to 1.
- **Back-to-back:** push 8'hA5 then 8'h3C on consecutive cycles -> two frames with zero idle cycles between the stop bit and the next start bit; STATUS busy=1 throughout.
- **Overflow:** with `FIFO_DEPTH=8`, push 10 bytes in 10 cycles while the first frame is in START -> the first 9 bytes are transmitted in order (one in the shift register plus 8 queued), the 10th is dropped, and STATUS bit 4 = 1. A write to STATUS clears it to 0.
- **Address decode:** read `BASE_ADDR+8` and write `BASE_ADDR-4` -> `ReadData=0` and no push; read `BASE_ADDR+6` -> returns STATUS (low bits ignored).
- **Parity build:** with `UART_TX_PARITY_EN`, send 8'h07 -> parity bit 1 and frame length 44 cycles at `CLKS_PER_BIT=4`.

Source files
------------

// File: rtl/mips_uart_tx_port_if.sv
// MEM-stage data-bus slice shared by the data memory and the UART transmit port.
interface mips_uart_tx_port_if;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (output MemWrite, MemRead, Address, WriteData, input ReadData);
  modport slave  (input MemWrite, MemRead, Address, WriteData, output ReadData);
endinterface

// File: rtl/mips_uart_tx_port.sv
// Memory-mapped UART transmitter: TXDATA pushes bytes into a FIFO drained as 8N1 frames.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between the data and stop bits.
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit, line low
// DATA   | eight data bits, LSB first
// PARITY | even parity of the data byte (parity build only)
// STOP   | stop bit, line high; then next frame or IDLE
module mips_uart_tx_port #(
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0040,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  mips_uart_tx_port_if.slave   bus,
  output logic                 Tx,
  output logic                 Irq
);
  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam int              BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]   BAUD_ONE  = BW'(1);
  localparam logic [AW:0]     PTR_ONE   = (AW+1)'(1);
  localparam logic [31:0]     STAT_ADDR = BASE_ADDR + 32'd4;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic          sel_data, sel_stat;
  logic          push_req, push_ok, pop;
  logic          fifo_full, fifo_empty;
  logic          overflow_q, busy;
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [7:0]    fifo_head;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          baud_end, tx_d;
  logic          unused_bits;

  assign sel_data    = bus.Address[31:2] == BASE_ADDR[31:2];
  assign sel_stat    = bus.Address[31:2] == STAT_ADDR[31:2];
  assign unused_bits = ^{bus.Address[1:0], bus.WriteData[31:8]};

  assign fifo_empty = wr_ptr_q == rd_ptr_q;
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_head  = mem[rd_ptr_q[AW-1:0]];

  // A pop on the same edge frees the slot the full-FIFO push lands in.
  assign push_req = bus.MemWrite && sel_data;
  assign push_ok  = push_req && (!fifo_full || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (bus.MemWrite && sel_stat)  overflow_q <= 1'b0;
      else if (push_req && !push_ok) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= bus.WriteData[7:0];
  end

`ifdef UART_TX_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    par_q <= 1'b0;
    else if (pop) par_q <= ^fifo_head;
  end
`endif

  assign baud_end = baud_q == BAUD_LAST;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BAUD_ONE;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit when data is waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            bit_d   = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase

    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      Tx      <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      Tx      <= tx_d;
    end
  end

  assign busy = state_q != IDLE;
  assign Irq  = (state_q == IDLE) && fifo_empty;

  always_comb begin
    bus.ReadData = '0;
    if (bus.MemRead && sel_stat)
      bus.ReadData = {27'b0, overflow_q, fifo_empty, fifo_full, busy, Irq};
  end
endmodule

// File: tb/tb_mips_uart_tx_port.sv
// Randomised bench for mips_uart_tx_port: a per-byte pop schedule derived from push
// times predicts Tx, Irq and STATUS after every clock edge.
module tb_mips_uart_tx_port;
  localparam logic [31:0] BASE  = 32'h1001_0040;
  localparam logic [31:0] STAT  = BASE + 32'd4;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int          NBITS = 11;
`else
  localparam int          NBITS = 10;
`endif
  localparam int          F     = NBITS * CPB;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic tx, irq;
  mips_uart_tx_port_if bus ();

  mips_uart_tx_port #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .Tx    (tx),
    .Irq   (irq)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;
  logic [31:0] rd_last;

  // Reference: accepted bytes with the edge they were pushed on and popped on.
  int m_data[$];
  int m_push[$];
  int m_pop[$];
  bit m_ovf = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  function automatic bit frame_bit(input int d, input int k);
    logic [7:0] b;
    b = d[7:0];
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (NBITS == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction

  function automatic bit exp_tx(input int t);
    foreach (m_pop[i])
      if (m_pop[i] <= t && t < m_pop[i] + F) return frame_bit(m_data[i], (t - m_pop[i]) / CPB);
    return 1'b1;
  endfunction

  function automatic int occ_at(input int t);
    int n = 0;
    foreach (m_push[i]) if (m_push[i] <= t && m_pop[i] > t) n++;
    return n;
  endfunction

  function automatic bit busy_at(input int t);
    foreach (m_pop[i]) if (m_pop[i] <= t && t < m_pop[i] + F) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] addr, input int t);
    int  o;
    bit  b;
    if (addr[31:2] != STAT[31:2]) return 32'h0;
    o = occ_at(t);
    b = busy_at(t);
    return {27'b0, m_ovf, (o == 0), (o == DEPTH), b, (!b && o == 0)};
  endfunction

  // Push landing on edge e: accepted unless full with no pop on that edge.
  task automatic model_push(input int e, input int d);
    int occ = 0;
    bit popnow = 1'b0;
    int p;
    foreach (m_push[i]) begin
      if (m_push[i] < e && m_pop[i] >= e) occ++;
      if (m_pop[i] == e) popnow = 1'b1;
    end
    if (occ == DEPTH && !popnow) begin
      m_ovf = 1'b1;
      return;
    end
    p = e + 1;
    if (m_pop.size() > 0 && m_pop[$] + F > p) p = m_pop[$] + F;
    m_data.push_back(d);
    m_push.push_back(e);
    m_pop.push_back(p);
  endtask

  task automatic model_clear();
    m_data.delete();
    m_push.delete();
    m_pop.delete();
    m_ovf = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("tx", {31'b0, tx}, {31'b0, exp_tx(edge_n)});
      check_eq("irq", {31'b0, irq}, {31'b0, (!busy_at(edge_n) && occ_at(edge_n) == 0)});
    end
  end

  task automatic bus_cycle(input bit we, input bit re, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    bus.MemWrite  = we;
    bus.MemRead   = re;
    bus.Address   = addr;
    bus.WriteData = wd;
    if (re) begin
      #1;
      rd_last = bus.ReadData;
      check_eq("rdata", rd_last, exp_rdata(addr, edge_n));
    end
    if (we && addr[31:2] == BASE[31:2]) model_push(edge_n + 1, int'(wd[7:0]));
    if (we && addr[31:2] == STAT[31:2]) m_ovf = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) bus_cycle(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  logic [31:0] addrs [6];
  int p0;
  int r;

  initial begin
    addrs[0] = BASE;        addrs[1] = STAT;        addrs[2] = BASE + 32'd8;
    addrs[3] = BASE - 32'd4; addrs[4] = BASE + 32'd1; addrs[5] = STAT + 32'd2;
    bus.MemWrite = 1'b0; bus.MemRead = 1'b0; bus.Address = '0; bus.WriteData = '0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    mon_en = 1'b1;

    // reset state
    bus_cycle(1'b0, 1'b1, STAT, 32'h0);
    check_eq("rst_status", rd_last, 32'h9);
    bus_cycle(1'b0, 1'b1, BASE, 32'h0);
    check_eq("rst_txdata", rd_last, 32'h0);

    // single byte, then line idles with Irq back high
    bus_cycle(1'b1, 1'b0, BASE, 32'h0000_0155);
    idle(F + 6);
    check_eq("irq_after_frame", {31'b0, irq}, 32'h1);

    // back-to-back frames with STATUS polled every cycle
    bus_cycle(1'b1, 1'b0, BASE, 32'hA5);
    bus_cycle(1'b1, 1'b0, BASE, 32'h3C);
    repeat (2 * F + 4) bus_cycle(1'b0, 1'b1, STAT, 32'h0);

    // overflow: ten pushes, the tenth finds the FIFO full
    for (int i = 0; i < 10; i++) bus_cycle(1'b1, 1'b0, BASE, 32'h10 + i);
    bus_cycle(1'b0, 1'b1, STAT, 32'h0);
    check_eq("ovf_set", {31'b0, rd_last[4]}, 32'h1);
    bus_cycle(1'b1, 1'b0, STAT + 32'd3, 32'hFFFF_FFFF);
    bus_cycle(1'b0, 1'b1, STAT, 32'h0);
    check_eq("ovf_clr", {31'b0, rd_last[4]}, 32'h0);
    idle(10 * F);

    // address decode
    bus_cycle(1'b0, 1'b1, BASE + 32'd8, 32'h0);
    check_eq("dec_plus8", rd_last, 32'h0);
    bus_cycle(1'b1, 1'b0, BASE - 32'd4, 32'h77);
    bus_cycle(1'b0, 1'b1, BASE + 32'd6, 32'h0);
    check_eq("dec_plus6", rd_last, 32'h9);
    idle(F);

    // parity-interesting byte
    bus_cycle(1'b1, 1'b0, BASE, 32'h07);
    idle(F + 4);

    // random traffic: heavy push phase then light phase
    for (int i = 0; i < 1200; i++) begin
      r = $urandom_range(0, 99);
      if (r < ((i < 500) ? 30 : 4))
        bus_cycle(1'b1, 1'b0, BASE + 32'($urandom_range(0, 3)), $urandom);
      else if (r < 40)
        bus_cycle(1'b0, 1'b1, addrs[$urandom_range(0, 5)], 32'h0);
      else if (r < 44)
        bus_cycle(1'b1, 1'b0, addrs[$urandom_range(1, 3)], $urandom);
      else if (r < 50)
        bus_cycle(1'b1, 1'b1, addrs[$urandom_range(0, 5)], $urandom);
      else
        idle(1);
    end
    idle((DEPTH + 2) * F);

    // reset in the middle of a stop bit with bytes still queued
    bus_cycle(1'b1, 1'b0, BASE, 32'h5A);
    p0 = m_pop[$];
    bus_cycle(1'b1, 1'b0, BASE, 32'hC3);
    bus_cycle(1'b1, 1'b0, BASE, 32'h11);
    while (edge_n < p0 + F - 3) idle(1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check_eq("rst_mid_tx", {31'b0, tx}, 32'h1);
    check_eq("rst_mid_irq", {31'b0, irq}, 32'h1);
    bus.MemRead = 1'b1;
    bus.Address = STAT;
    #1;
    check_eq("rst_mid_status", bus.ReadData, 32'h9);
    bus.MemRead = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    idle(2 * F);
    bus_cycle(1'b0, 1'b1, STAT, 32'h0);
    check_eq("post_rst_status", rd_last, 32'h9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
